io_loopback_checker: RTL and testbench



---
 rtl/io_loopback_checker_pkg.sv | 45 ++++
 rtl/io_loopback_checker_sync2.sv | 26 ++
 rtl/io_loopback_checker.sv | 128 ++++++++++++
 tb/tb_io_loopback_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_loopback_checker_pkg.sv
// Shared types and helpers for the header loopback checker.
//   mode_t           : pattern select (ALT, WALK1, WALK0, RSVD; RSVD behaves as ALT)
//   state_t          : checker FSM states
//   ERR_CNT_W        : width of the saturating mismatch counter
//   pattern()        : test vector for a given mode/step, bits >= width forced to 0
//   lowest_set_index : index of the least-significant set bit (0 if none)
package io_test_pkg;

  typedef enum logic [1:0] {ALT = 2'd0, WALK1 = 2'd1, WALK0 = 2'd2, RSVD = 2'd3} mode_t;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned MAX_W     = 64;

  function automatic logic [63:0] pattern(input mode_t mode, input logic [6:0] step,
                                          input int unsigned width);
    logic [63:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        case (mode)
          WALK1:   p[i] = (i == 32'(step));
          WALK0:   p[i] = (i != 32'(step));
          default: p[i] = ~i[0] ^ step[0];
        endcase
      end
    end
    return p;
  endfunction

  function automatic logic [5:0] lowest_set_index(input logic [63:0] v);
    logic [5:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (v[i] && !found) begin
        idx   = 6'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_loopback_checker_sync2.sv
// io_sync2: WIDTH-wide two-flop synchronizer for the asynchronous loopback inputs.
//   clk, rst : clock and synchronous active-high reset (clears both stages)
//   d        : asynchronous input vector
//   q        : synchronized output vector
module io_sync2 #(
  parameter int unsigned WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_loopback_checker.sv
// io_loopback_checker: drives a deterministic pattern onto a header bank and
// checks the looped-back bank, reporting pass/fail, a saturating mismatch count
// and the first failing step/bit.
//   clk, rst        : clock, synchronous active-high reset (aborts any run)
//   start           : single-cycle run request (ignored while busy)
//   mode            : 0 alternating, 1 walking-one, 2 walking-zero, 3 as 0
//   tx_io           : pattern driven to the header (0 when not running)
//   rx_io           : looped-back header inputs (asynchronous)
//   busy, done      : run in progress / run finished (done held until start/rst)
//   pass            : valid with done, 1 iff no mismatching step
//   err_cnt         : mismatching steps, saturating
//   err_valid       : at least one mismatch recorded
//   first_err_bit   : lowest mismatching bit of the first failing step
//   first_err_step  : step index of the first failing step
module io_loopback_checker
  import io_test_pkg::*;
#(
  parameter int unsigned WIDTH         = 39,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     tx_io,
  input  logic [WIDTH-1:0]     rx_io,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_valid,
  output logic [5:0]           first_err_bit,
  output logic [6:0]           first_err_step
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  state_t           state;
  mode_t            run_mode;
  logic [6:0]       step;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] rx_sync;
  logic [63:0]      start_pat;
  logic [63:0]      next_pat;
  logic [63:0]      diff;
  logic             mismatch;
  logic [6:0]       last_step;

  io_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_io),
    .q   (rx_sync)
  );

  always_comb begin
    start_pat = pattern(mode_t'(mode), 7'd0, WIDTH);
    next_pat  = pattern(run_mode, step + 7'd1, WIDTH);
    diff      = 64'(rx_sync ^ tx_io);
    mismatch  = |diff;
    last_step = (run_mode == WALK1 || run_mode == WALK0) ? 7'(WIDTH - 1) : 7'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      run_mode       <= ALT;
      step           <= '0;
      settle_cnt     <= '0;
      tx_io          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      err_valid      <= 1'b0;
      first_err_bit  <= '0;
      first_err_step <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DRIVE;
            run_mode       <= mode_t'(mode);
            step           <= '0;
            settle_cnt     <= '0;
            tx_io          <= start_pat[WIDTH-1:0];
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            err_valid      <= 1'b0;
            first_err_bit  <= '0;
            first_err_step <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!err_valid) begin
              err_valid      <= 1'b1;
              first_err_bit  <= lowest_set_index(diff);
              first_err_step <= step;
            end
          end
          if (step == last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err_valid is not yet updated for this step's result.
            pass  <= ~(err_valid | mismatch);
            tx_io <= '0;
          end else begin
            state      <= DRIVE;
            step       <= step + 7'd1;
            settle_cnt <= '0;
            tx_io      <= next_pat[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_loopback_checker.sv
module tb_io_loopback_checker;

  localparam int W = 39;
  localparam int S = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  tx_io;
  logic [W-1:0]  rx_io;
  logic          busy, done, pass, err_valid;
  logic [15:0]   err_cnt;
  logic [5:0]    first_err_bit;
  logic [6:0]    first_err_step;

  int tests = 0;
  int fails = 0;
  int fault = 0;

  typedef struct {
    int err;
    int valid;
    int ebit;
    int estep;
    int pas;
  } res_t;

  logic [W-1:0] txq[$];
  res_t         resq[$];

  io_loopback_checker #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .tx_io          (tx_io),
    .rx_io          (rx_io),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .err_valid      (err_valid),
    .first_err_bit  (first_err_bit),
    .first_err_step (first_err_step)
  );

  always #5 clk = ~clk;

  // external loopback harness with optional planted board faults
  always_comb begin
    rx_io = tx_io;
    case (fault)
      1: rx_io[7] = 1'b0;
      2: begin
        rx_io[3] = tx_io[3] | tx_io[4];
        rx_io[4] = tx_io[3] | tx_io[4];
      end
      3: rx_io = '1;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_pat(input int m, input int k);
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) begin
      case (m)
        1: p[i] = (i == k);
        2: p[i] = (i != k);
        default: p[i] = ((i % 2) == 0) != ((k % 2) == 1);
      endcase
    end
    return p;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 64'(tx_io), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_errvalid"}, 64'(err_valid), 64'd0);
    check({tag, "_ebit"}, 64'(first_err_bit), 64'd0);
    check({tag, "_estep"}, 64'(first_err_step), 64'd0);
  endtask

  // Runs one full pattern sequence; poke_at > 0 pulses start again mid-run.
  task automatic run(input int m, input int n, input int poke_at, input res_t r);
    int   c;
    int   done_c;
    int   k;
    res_t got;
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) txq.push_back(exp_pat(m, i));
    resq.push_back(r);
    mode  = 2'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 2'(m ^ 1);
    c = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("errcnt_cleared", 64'(err_cnt), 64'd0);
    check("errvalid_cleared", 64'(err_valid), 64'd0);
    done_c = 0;
    while (done_c == 0 && c < 3000) begin
      k = (c - 1) / (S + 1);
      if ((c - 1 - k * (S + 1)) == 5 && k < n && txq.size() > 0) begin
        e = txq.pop_front();
        check($sformatf("tx_step%0d", k), 64'(tx_io), 64'(e));
      end
      if (c == poke_at) start = 1'b1;
      tick();
      start = 1'b0;
      c++;
      if (done) done_c = c;
    end
    check("done_cycle", 64'(done_c), 64'(1 + n * (S + 1)));
    check("tx_zero_done", 64'(tx_io), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    got = resq.pop_front();
    check("err_cnt", 64'(err_cnt), 64'(got.err));
    check("err_valid", 64'(err_valid), 64'(got.valid));
    check("first_err_bit", 64'(first_err_bit), 64'(got.ebit));
    check("first_err_step", 64'(first_err_step), 64'(got.estep));
    check("pass", 64'(pass), 64'(got.pas));
    tick();
    check("done_held", 64'(done), 64'd1);
  endtask

  initial begin
    int c;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    fault = 0;
    run(1, W, 50, '{err: 0, valid: 0, ebit: 0, estep: 0, pas: 1});

    fault = 1;
    run(1, W, 0, '{err: 1, valid: 1, ebit: 7, estep: 7, pas: 0});

    fault = 2;
    run(0, 2, 0, '{err: 2, valid: 1, ebit: 3, estep: 0, pas: 0});

    fault = 3;
    run(2, W, 0, '{err: W, valid: 1, ebit: 0, estep: 0, pas: 0});

    fault = 0;
    run(3, 2, 0, '{err: 0, valid: 0, ebit: 0, estep: 0, pas: 1});

    // abort a walking-one run with a faulty board partway through
    fault = 3;
    mode  = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 200) begin
      tick();
      c++;
    end
    check("abort_running_errs", 64'(err_valid), 64'd1);
    rst = 1'b1;
    tick();
    check_idle("abort");
    rst = 1'b0;
    tick();
    check_idle("post_abort");

    fault = 0;
    run(1, W, 0, '{err: 0, valid: 0, ebit: 0, estep: 0, pas: 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
